// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and D-cache stores.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous D/I misses instead of fixed D-first priority.
module mem_fill_arbiter #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned WIDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [15:0]       i_addr,
    input  logic              d_miss,
    input  logic              d_wr,
    input  logic [15:0]       d_addr,
    input  logic [15:0]       d_wdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_data_valid,
    output logic [15:0]       fill_data,
    output logic [WIDX_W-1:0] fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StWrite, StIssue, StDrain, StDone} state_e;
    typedef enum logic [1:0] {OwnNone, OwnI, OwnD, OwnW} owner_e;

    localparam logic [15:0]       OffsMask = 16'(2 * BLOCK_WORDS - 1);
    localparam logic [WIDX_W-1:0] LastWord = WIDX_W'(BLOCK_WORDS - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [WIDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [WIDX_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              grant_d;
    logic              returning;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the winner of the last contested D/I miss; resets to I so D wins first.
    logic last_d_q, last_d_d;
    logic tie;
    assign tie     = d_miss && i_miss;
    assign grant_d = d_miss && (!i_miss || !last_d_q);
`else
    assign grant_d = d_miss;
`endif

    assign returning = (state_q == StIssue || state_q == StDrain) && mem_data_valid;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`endif
        unique case (state_q)
            StIdle: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                if (d_wr) begin
                    state_d = StWrite;
                    owner_d = OwnW;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (d_miss || i_miss) begin
                    state_d = StIssue;
                    owner_d = grant_d ? OwnD : OwnI;
                    addr_d  = (grant_d ? d_addr : i_addr) & ~OffsMask;
`ifdef ARB_ROUND_ROBIN_EN
                    if (tie) last_d_d = grant_d;
`endif
                end
            end
            StWrite: state_d = StDone;
            StIssue: begin
                issue_cnt_d = issue_cnt_q + WIDX_W'(1);
                if (issue_cnt_q == LastWord) state_d = StDrain;
            end
            StDrain: begin
            end
            StDone: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
            default: state_d = StIdle;
        endcase
        // The final return ends the fill even if it arrives while still issuing.
        if (returning) begin
            ret_cnt_d = ret_cnt_q + WIDX_W'(1);
            if (ret_cnt_q == LastWord) state_d = StDone;
        end
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            StWrite: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
            end
            StIssue: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q + (16'(issue_cnt_q) << 1);
            end
            default: begin
            end
        endcase
    end

    assign fill_data   = mem_rdata;
    assign fill_word   = ret_cnt_q;
    assign i_fill_we   = returning && (owner_q == OwnI);
    assign d_fill_we   = returning && (owner_q == OwnD);
    assign i_fill_done = (state_q == StDone) && (owner_q == OwnI);
    assign d_fill_done = (state_q == StDone) && (owner_q == OwnD);
    assign d_wr_done   = (state_q == StDone) && (owner_q == OwnW);
    assign busy        = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OwnNone;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d_q <= 1'b0;
        else        last_d_q <= last_d_d;
    end
`endif

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: cycle vectors, directed fills and random traffic against
// a transaction-level model of the arbiter and a fixed-latency identity memory.
module tb_mem_fill_arbiter;

    localparam int BW = 8;
    localparam logic [15:0] SpurData = 16'hA5C3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic i_miss = 0, d_miss = 0, d_wr = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic mem_enable, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0] fill_word;
    logic i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;
    logic spur = 1'b0;

    always #5 clk = ~clk;

    mem_fill_arbiter #(.BLOCK_WORDS(BW), .WIDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_done(d_wr_done),
        .busy(busy)
    );

    // Memory: word at byte address a holds a; a read accepted in cycle c returns in c+lat.
    int lat = 4;
    bit [16:0] pipe [8];
    always @(posedge clk) begin
        for (int k = 7; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= {mem_enable && !mem_wr, (mem_enable && !mem_wr) ? mem_addr : 16'h0};
    end
    assign mem_data_valid = pipe[lat-1][16] | spur;
    assign mem_rdata = pipe[lat-1][16] ? pipe[lat-1][15:0] : (spur ? SpurData : 16'h0);

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] pack(input logic en, wr, input logic [15:0] a, wd,
                                         input logic ifw, dfw, input logic [2:0] w,
                                         input logic [15:0] fd, input logic idn, ddn, wdn, bsy);
        return {5'b0, en, wr, a, wd, ifw, dfw, w, fd, idn, ddn, wdn, bsy};
    endfunction

    function automatic logic [63:0] act_vec(input bit m);
        return pack(mem_enable, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we,
                    m ? fill_word : 3'd0, m ? fill_data : 16'd0,
                    i_fill_done, d_fill_done, d_wr_done, busy);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // Transaction-level model: requester levels plus the transaction in service.
    typedef enum int {KNone, KW, KD, KI} kind_e;
    kind_e cur = KNone;
    int r = 0;
    logic [15:0] cur_base, cur_wdata;
    bit pend_w, pend_d, pend_i;
    logic [15:0] w_addr, w_data, dm_addr, im_addr;
    bit last_i = 1'b1;
    int raises;

    task automatic drive_reqs();
        d_wr    = pend_w;
        d_miss  = pend_d;
        i_miss  = pend_i;
        d_addr  = pend_w ? w_addr : dm_addr;
        d_wdata = w_data;
        i_addr  = im_addr;
    endtask

    task automatic model_cycle(output logic [63:0] e, output bit we, output bit dn);
        logic en, wr, ifw, dfw, idn, ddn, wdn, bsy;
        logic [15:0] a, wd, fd;
        logic [2:0] w;
        int k;
        bit take_d;
        en = 0; wr = 0; ifw = 0; dfw = 0; idn = 0; ddn = 0; wdn = 0; bsy = 0;
        a = 0; wd = 0; fd = 0; w = 0; we = 0; dn = 0;
        if (cur == KNone) begin
            if (pend_w) begin
                cur = KW; cur_base = w_addr; cur_wdata = w_data;
            end else if (pend_d || pend_i) begin
                take_d = pend_d;
`ifdef ARB_ROUND_ROBIN_EN
                if (pend_d && pend_i) begin
                    take_d = last_i;
                    last_i = !take_d;
                end
`endif
                cur = take_d ? KD : KI;
                cur_base = (take_d ? dm_addr : im_addr) & 16'hFFF0;
            end
            r = 0;
        end else begin
            r++;
            bsy = 1;
            if (cur == KW) begin
                if (r == 1) begin en = 1; wr = 1; a = cur_base; wd = cur_wdata; end
                if (r == 2) begin wdn = 1; dn = 1; end
            end else begin
                if (r <= BW) begin en = 1; a = cur_base + 16'(2 * (r - 1)); end
                k = r - 1 - lat;
                if (k >= 0 && k < BW) begin
                    we = 1; w = 3'(k); fd = cur_base + 16'(2 * k);
                    if (cur == KI) ifw = 1; else dfw = 1;
                end
                if (r == lat + BW + 1) begin
                    dn = 1;
                    if (cur == KI) idn = 1; else ddn = 1;
                end
            end
        end
        e = pack(en, wr, a, wd, ifw, dfw, w, fd, idn, ddn, wdn, bsy);
    endtask

    task automatic tick(input string name);
        logic [63:0] e;
        bit we, dn;
        @(negedge clk);
        drive_reqs();
        #1;
        model_cycle(e, we, dn);
        check(name, act_vec(we), e);
        if (dn) begin
            if (cur == KW) pend_w = 0;
            else if (cur == KD) pend_d = 0;
            else pend_i = 0;
            cur = KNone;
            drive_reqs();
        end
    endtask

    task automatic raise_random();
        int t;
        t = $urandom_range(0, 2);
        if (t == 0 && !pend_w) begin
            pend_w = 1; w_addr = 16'($urandom); w_data = 16'($urandom); raises++;
        end else if (t == 1 && !pend_d) begin
            pend_d = 1; dm_addr = 16'($urandom); raises++;
        end else if (t == 2 && !pend_i) begin
            pend_i = 1; im_addr = 16'($urandom); raises++;
        end
    endtask

    task automatic run_episode(input string name, input bit w, d, i,
                               input logic [15:0] wa, wdat, da, ia, input int L, input bit extra);
        int budget;
        tick(name);
        if (L != lat) begin
            repeat (8) tick(name);
            lat = L;
        end
        pend_w = w; pend_d = d; pend_i = i;
        w_addr = wa; w_data = wdat; dm_addr = da; im_addr = ia;
        raises = 0;
        budget = 300;
        while ((pend_w || pend_d || pend_i || cur != KNone) && budget > 0) begin
            if (extra && cur != KNone && raises < 2 && $urandom_range(0, 15) == 0)
                raise_random();
            tick(name);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: episode timeout, got busy=%0b want idle", name, busy);
            pend_w = 0; pend_d = 0; pend_i = 0; cur = KNone;
        end
    endtask

    typedef struct {
        logic rst; logic wr; logic sp; logic [15:0] addr; logic [15:0] wdata;
        logic en_e; logic wr_e; logic [15:0] addr_e; logic [15:0] wdata_e;
        logic wdone_e; logic busy_e;
    } vec_t;
    vec_t vecs [12];

    initial begin
        logic [2:0] sel;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0457, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0457, 16'h1111, 1'b1, 1'b1, 16'h0457, 16'h1111, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0457, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("reset outputs", act_vec(1'b1), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cycle vectors: stores, spurious returns in IDLE, reset during DONE.
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            rst_n = vecs[v].rst; d_wr = vecs[v].wr; spur = vecs[v].sp;
            d_addr = vecs[v].addr; d_wdata = vecs[v].wdata; i_miss = 0; d_miss = 0;
            #1;
            check($sformatf("vec%0d", v), act_vec(1'b0),
                  pack(vecs[v].en_e, vecs[v].wr_e, vecs[v].addr_e, vecs[v].wdata_e, 1'b0, 1'b0,
                       3'd0, 16'd0, 1'b0, 1'b0, vecs[v].wdone_e, vecs[v].busy_e));
            if (vecs[v].sp) check($sformatf("vec%0d fill_data", v), 64'(fill_data), 64'(SpurData));
        end
        spur = 0;
        last_i = 1'b1;

        run_episode("i_miss 0036", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0036, 4, 0);
        run_episode("wr+d+i", 1, 1, 1, 16'h2222, 16'h3333, 16'h4448, 16'h555A, 4, 0);
        run_episode("d+i pair", 0, 1, 1, 16'h0, 16'h0, 16'h6666, 16'h7777, 4, 0);
        run_episode("wrap fff2", 0, 1, 0, 16'h0, 16'h0, 16'hFFF2, 16'h0, 4, 0);

        // Reset in cycle 7 of an I fill while returns are still in flight.
        tick("rst_mid idle");
        pend_i = 1; im_addr = 16'h0036;
        repeat (7) tick("rst_mid fill");
        @(negedge clk);
        rst_n = 1'b0; pend_i = 0; cur = KNone; last_i = 1'b1;
        drive_reqs();
        #1;
        check("rst_mid outputs", act_vec(1'b1) & ~64'(16'hFFFF << 4),
              pack(0, 0, 16'h0, 16'h0, 0, 0, 3'd0, 16'h0, 0, 0, 0, 0));
        check("rst_mid fill_data", 64'(fill_data), 64'(mem_rdata));
        @(negedge clk);
        #1;
        check("rst_mid held", act_vec(1'b0), 64'h0);
        rst_n = 1'b1;
        repeat (8) tick("rst_mid stray");

        for (int e = 0; e < 40; e++) begin
            sel = 3'($urandom_range(1, 7));
            run_episode($sformatf("rand%0d", e), sel[2], sel[1], sel[0],
                        16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        int'($urandom_range(1, 8)), 1);
        end
        repeat (2) tick("final idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
